// File: rtl/sm510_cpu.sv
// Sharp SM510 4-bit microcontroller core, stepped one stage per clk_en.
// Fetches opcodes from an external registered 4K ROM and executes them
// against internal RAM, accumulator, pointer, W shifter and divider state.
module sm510_cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [7:0]  rom_data,
    output logic [11:0] rom_addr,
    input  logic [3:0]  input_k,
    input  logic        input_ba,
    input  logic        input_beta,
    output logic [7:0]  output_shifter_s
);

    typedef enum logic [2:0] {
        ST_LOAD_PC       = 3'd0,
        ST_DECODE_PERF_1 = 3'd1,
        ST_LOAD_2        = 3'd2,
        ST_DECODE_PERF_2 = 3'd3,
        ST_TM_LOAD       = 3'd4,
        ST_TM_PERF       = 3'd5,
        ST_RESERVED      = 3'd6,
        ST_SKIP          = 3'd7
    } stage_t;

    stage_t      r_stage, w_stage_nxt;
    logic [11:0] r_pc, r_stack_s, r_stack_r;
    logic [7:0]  r_op, r_w;
    logic [3:0]  r_acc, r_bl;
    logic [2:0]  r_bm;
    logic        r_carry, r_gamma, r_skip, r_lax, r_sbm;
    logic [14:0] r_div;
    logic [3:0]  r_ram [0:127];

    logic [11:0] w_pc_nxt, w_s_nxt, w_r_nxt, w_pc_inc;
    logic [7:0]  w_op_nxt, w_w_nxt;
    logic [3:0]  w_acc_nxt, w_bl_nxt, w_m, w_bit, w_ram_wdata;
    logic [2:0]  w_bm_nxt;
    logic        w_carry_nxt, w_gamma_nxt, w_skip_nxt, w_lax_nxt, w_sbm_nxt;
    logic [14:0] w_div_nxt;
    logic        w_ram_we, w_first, w_is_lax, w_two_byte, w_discard, w_exec;
    logic [6:0]  w_ram_addr;
    logic [4:0]  w_addc, w_adx;

    // Program counter step field is a 6-bit LFSR; the page never changes here.
    function automatic logic [11:0] f_pc_step(input logic [11:0] pc);
        return {pc[11:6], ~(pc[0] ^ pc[1]), pc[5:1]};
    endfunction

    // First-byte stages see the opcode directly on rom_data.
    assign w_first    = (r_stage == ST_DECODE_PERF_1) || (r_stage == ST_SKIP);
    assign w_is_lax   = (rom_data[7:4] == 4'h2);
    assign w_two_byte = (rom_data == 8'h5F) || (rom_data[7:4] == 4'h7);
    // SKIP is also entered speculatively after a LAX; only a chained LAX is dropped.
    assign w_discard  = (r_stage == ST_SKIP) && (r_skip || w_is_lax);
    assign w_exec     = w_first && !w_discard;

    // SBM forces the high Bm bit for exactly one instruction.
    assign w_ram_addr = {r_bm[2] | r_sbm, r_bm[1:0], r_bl};
    assign w_m        = r_ram[w_ram_addr];
    assign w_pc_inc   = f_pc_step(r_pc);
    assign w_bit      = 4'b0001 << rom_data[1:0];
    assign w_addc     = {1'b0, r_acc} + {1'b0, w_m} + {4'b0000, r_carry};
    assign w_adx      = {1'b0, r_acc} + {1'b0, rom_data[3:0]};

    // TM reads its vector from page 0; everything else fetches at pc.
    assign rom_addr         = (r_stage == ST_TM_LOAD) ? {6'd0, r_op[5:0]} : r_pc;
    assign output_shifter_s = r_w;

    // Stage sequencing: one stage per clk_en, back to LOAD_PC after execution.
    always_comb begin
        w_stage_nxt = ST_LOAD_PC;
        case (r_stage)
            ST_LOAD_PC:
                w_stage_nxt = (r_skip || r_lax) ? ST_SKIP : ST_DECODE_PERF_1;
            ST_DECODE_PERF_1, ST_SKIP:
                if (w_two_byte)
                    w_stage_nxt = ST_LOAD_2;
                else if (w_exec && (rom_data[7:6] == 2'b11))
                    w_stage_nxt = ST_TM_LOAD;
            ST_LOAD_2:  w_stage_nxt = ST_DECODE_PERF_2;
            ST_TM_LOAD: w_stage_nxt = ST_TM_PERF;
            default:    w_stage_nxt = ST_LOAD_PC;
        endcase
    end

    // Instruction execution: next values for every architectural register.
    always_comb begin
        w_pc_nxt    = r_pc;
        w_s_nxt     = r_stack_s;
        w_r_nxt     = r_stack_r;
        w_op_nxt    = r_op;
        w_w_nxt     = r_w;
        w_acc_nxt   = r_acc;
        w_bl_nxt    = r_bl;
        w_bm_nxt    = r_bm;
        w_carry_nxt = r_carry;
        w_gamma_nxt = r_gamma;
        w_skip_nxt  = r_skip;
        w_lax_nxt   = r_lax;
        w_sbm_nxt   = r_sbm;
        w_div_nxt   = r_div + 15'd1;
        w_ram_we    = 1'b0;
        w_ram_wdata = r_acc;

        if (w_first) begin
            w_op_nxt  = rom_data;
            w_pc_nxt  = w_pc_inc;
            w_lax_nxt = w_is_lax;
            w_sbm_nxt = 1'b0;
            // A discarded two-byte op keeps skip set so its operand is dropped too.
            w_skip_nxt = w_discard ? w_two_byte : 1'b0;
        end

        if (w_exec) begin
            casez (rom_data)
                8'h02:        w_sbm_nxt = 1'b1;
                8'b0000_01??: begin w_ram_we = 1'b1; w_ram_wdata = w_m & ~w_bit; end
                8'b0000_11??: begin w_ram_we = 1'b1; w_ram_wdata = w_m | w_bit; end
                8'h08:        w_acc_nxt = r_acc + w_m;
                8'h09: begin
                    w_acc_nxt   = w_addc[3:0];
                    w_carry_nxt = w_addc[4];
                    w_skip_nxt  = w_addc[4];
                end
                8'h0A:        w_acc_nxt = ~r_acc;
                8'h0B: begin  w_acc_nxt = r_bl; w_bl_nxt = r_acc; end
                8'b0001_00??, 8'b0001_01??, 8'b0001_11??: begin
                    w_acc_nxt   = w_m;
                    w_ram_we    = 1'b1;
                    w_ram_wdata = r_acc;
                    w_bm_nxt    = {r_bm[2], r_bm[1:0] ^ rom_data[1:0]};
                    if (rom_data[3:2] == 2'b01) begin
                        w_bl_nxt   = r_bl + 4'd1;
                        w_skip_nxt = (r_bl == 4'hF);
                    end
                    if (rom_data[3:2] == 2'b11) begin
                        w_bl_nxt   = r_bl - 4'd1;
                        w_skip_nxt = (r_bl == 4'h0);
                    end
                end
                8'b0001_10??: begin
                    w_acc_nxt = w_m;
                    w_bm_nxt  = {r_bm[2], r_bm[1:0] ^ rom_data[1:0]};
                end
                8'b0010_????: w_acc_nxt = rom_data[3:0];
                8'b0011_????: begin
                    w_acc_nxt  = w_adx[3:0];
                    w_skip_nxt = w_adx[4] && (rom_data[3:0] != 4'hA);
                end
                8'b0100_????: begin
                    w_bm_nxt = {r_bm[2], rom_data[3:2]};
                    w_bl_nxt = {rom_data[1:0], rom_data[1:0]};
                end
                8'h51:        w_skip_nxt = input_beta;
                8'h52:        w_skip_nxt = !r_carry;
                8'h53:        w_skip_nxt = (r_acc == w_m);
                8'b0101_01??: w_skip_nxt = |(w_m & w_bit);
                8'h58: begin  w_skip_nxt = !r_gamma; w_gamma_nxt = 1'b0; end
                8'h5A:        w_skip_nxt = (r_acc == 4'h0);
                8'h5B:        w_skip_nxt = (r_acc == r_bl);
                8'h5E:        w_skip_nxt = input_ba;
                8'h62:        w_w_nxt = {r_w[6:0], 1'b0};
                8'h63:        w_w_nxt = {r_w[6:0], 1'b1};
                8'h64: begin  w_bl_nxt = r_bl + 4'd1; w_skip_nxt = (r_bl == 4'hF); end
                8'h65:        w_div_nxt = 15'd0;
                8'h66:        w_carry_nxt = 1'b0;
                8'h67:        w_carry_nxt = 1'b1;
                8'h68:        w_skip_nxt = r_div[14];
                8'h69:        w_skip_nxt = r_div[11];
                8'h6A:        w_acc_nxt = input_k;
                8'h6B: begin  w_acc_nxt = {r_carry, r_acc[3:1]}; w_carry_nxt = r_acc[0]; end
                8'h6C: begin  w_bl_nxt = r_bl - 4'd1; w_skip_nxt = (r_bl == 4'h0); end
                8'h6E, 8'h6F: begin
                    w_pc_nxt   = r_stack_s;
                    w_s_nxt    = r_stack_r;
                    w_skip_nxt = rom_data[0];
                end
                8'b10??_????: w_pc_nxt = {r_pc[11:6], rom_data[5:0]};
                8'b11??_????: begin w_s_nxt = w_pc_inc; w_r_nxt = r_stack_s; end
                default: ;
            endcase
        end

        // Second byte of LBL / TL / TML (or its discard when the op was skipped).
        if (r_stage == ST_DECODE_PERF_2) begin
            w_pc_nxt   = w_pc_inc;
            w_skip_nxt = 1'b0;
            if (!r_skip) begin
                if (r_op == 8'h5F) begin
                    w_bm_nxt = rom_data[6:4];
                    w_bl_nxt = rom_data[3:0];
                end else begin
                    // 7C-7F are TML: bits 3:2 select the call, only bits 1:0 feed the page.
                    w_pc_nxt = {(r_op[3:2] == 2'b11) ? 2'b00 : r_op[3:2], r_op[1:0], rom_data};
                    if (r_op[3:2] == 2'b11) begin
                        w_s_nxt = w_pc_inc;
                        w_r_nxt = r_stack_s;
                    end
                end
            end
        end

        // TM vector byte: two page bits plus fixed page pattern, then the step.
        if (r_stage == ST_TM_PERF)
            w_pc_nxt = {rom_data[7:6], 4'b0100, rom_data[5:0]};

        if (r_div == 15'h7FFF)
            w_gamma_nxt = 1'b1;
    end

    // Stage register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stage <= ST_LOAD_PC;
        else if (clk_en)
            r_stage <= w_stage_nxt;
    end

    // Architectural register update, gated by the step enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= 12'h0C0;
            r_stack_s <= 12'h000;
            r_stack_r <= 12'h000;
            r_op      <= 8'h00;
            r_w       <= 8'h00;
            r_acc     <= 4'h0;
            r_bl      <= 4'h0;
            r_bm      <= 3'd0;
            r_carry   <= 1'b0;
            r_gamma   <= 1'b0;
            r_skip    <= 1'b0;
            r_lax     <= 1'b0;
            r_sbm     <= 1'b0;
            r_div     <= 15'd0;
        end else if (clk_en) begin
            r_pc      <= w_pc_nxt;
            r_stack_s <= w_s_nxt;
            r_stack_r <= w_r_nxt;
            r_op      <= w_op_nxt;
            r_w       <= w_w_nxt;
            r_acc     <= w_acc_nxt;
            r_bl      <= w_bl_nxt;
            r_bm      <= w_bm_nxt;
            r_carry   <= w_carry_nxt;
            r_gamma   <= w_gamma_nxt;
            r_skip    <= w_skip_nxt;
            r_lax     <= w_lax_nxt;
            r_sbm     <= w_sbm_nxt;
            r_div     <= w_div_nxt;
        end
    end

    // Data RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (clk_en && w_ram_we)
            r_ram[w_ram_addr] <= w_ram_wdata;
    end

endmodule

// File: tb/tb_sm510_cpu.sv
// Directed testbench for sm510_cpu with a registered ROM model.
module tb_sm510_cpu;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic [7:0]  rom_data;
    logic [11:0] rom_addr;
    logic [3:0]  input_k;
    logic        input_ba;
    logic        input_beta;
    logic [7:0]  output_shifter_s;

    logic [7:0]  rom [0:4095];
    logic [11:0] wa;
    int          n_checks;
    int          n_errors;

    sm510_cpu dut (
        .clk              (clk),
        .reset            (reset),
        .clk_en           (clk_en),
        .rom_data         (rom_data),
        .rom_addr         (rom_addr),
        .input_k          (input_k),
        .input_ba         (input_ba),
        .input_beta       (input_beta),
        .output_shifter_s (output_shifter_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM: data for an address appears one clk_en later.
    always @(posedge clk) if (clk_en) rom_data <= rom[rom_addr];

    // Key matrix: K2 reads high when strobe S[2] is driven.
    assign input_k = output_shifter_s[2] ? 4'd4 : 4'd0;

    function automatic logic [11:0] lfsr(input logic [11:0] a);
        return {a[11:6], ~(a[0] ^ a[1]), a[5:1]};
    endfunction

    task automatic put(input logic [7:0] b);
        rom[wa] = b;
        wa = lfsr(wa);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        wa = 12'h0C0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        clk_en     = 1'b1;
        input_ba   = 1'b0;
        input_beta = 1'b0;

        // Reset state, clk_en gating, LFSR step, LAX chain
        do_reset();
        put(8'h25); put(8'h23);
        chk("rst_addr",  16'(rom_addr), 16'h00C0);
        chk("rst_stage", 16'(dut.r_stage), 16'd0);
        chk("rst_acc",   16'(dut.r_acc), 16'd0);
        chk("rst_carry", 16'(dut.r_carry), 16'd0);
        chk("rst_w",     16'(output_shifter_s), 16'h0000);
        chk("rst_gamma", 16'(dut.r_gamma), 16'd0);
        chk("rst_div",   16'(dut.r_div), 16'd0);
        clk_en = 1'b0;
        tick(3);
        chk("hold_stage", 16'(dut.r_stage), 16'd0);
        chk("hold_div",   16'(dut.r_div), 16'd0);
        chk("hold_addr",  16'(rom_addr), 16'h00C0);
        clk_en = 1'b1;
        tick(1);
        chk("lax_stage1", 16'(dut.r_stage), 16'd1);
        tick(1);
        chk("lfsr_addr", 16'(rom_addr), 16'h00E0);
        chk("lax5_acc",  16'(dut.r_acc), 16'd5);
        tick(1);
        chk("chain_stage7", 16'(dut.r_stage), 16'd7);
        tick(1);
        chk("chain_acc",  16'(dut.r_acc), 16'd5);
        chk("chain_addr", 16'(rom_addr), 16'h00F0);

        // ADX carry skip and no-skip
        do_reset();
        put(8'h29); put(8'h38); put(8'h34); put(8'h22); put(8'h31); put(8'h34);
        chk("rst2_acc", 16'(dut.r_acc), 16'd0);
        tick(4);
        chk("adx8_acc",  16'(dut.r_acc), 16'd1);
        chk("adx8_skip", 16'(dut.r_skip), 16'd1);
        tick(1);
        chk("adx_skip_stage", 16'(dut.r_stage), 16'd7);
        tick(1);
        chk("skipped_acc", 16'(dut.r_acc), 16'd1);
        tick(4);
        chk("adx1_acc",  16'(dut.r_acc), 16'd3);
        chk("adx1_skip", 16'(dut.r_skip), 16'd0);
        tick(2);
        chk("adx4_acc", 16'(dut.r_acc), 16'd7);

        // W shifter and key read
        do_reset();
        put(8'h63); put(8'h63); put(8'h62); put(8'h6A);
        tick(2);
        chk("ws_w", 16'(output_shifter_s), 16'h0001);
        tick(4);
        chk("wr_w", 16'(output_shifter_s), 16'h0006);
        tick(2);
        chk("kta_acc", 16'(dut.r_acc), 16'd4);

        // Divider wrap, gamma, TIS
        do_reset();
        put(8'h80);
        tick(32767);
        chk("div_7fff",   16'(dut.r_div), 16'h7FFF);
        chk("gamma_pre",  16'(dut.r_gamma), 16'd0);
        tick(1);
        chk("div_wrap",   16'(dut.r_div), 16'h0000);
        chk("gamma_set",  16'(dut.r_gamma), 16'd1);
        chk("loop_stage", 16'(dut.r_stage), 16'd0);
        wa = 12'h0C0;
        put(8'h58); put(8'h58); put(8'h27); put(8'h31);
        tick(2);
        chk("tis1_gamma", 16'(dut.r_gamma), 16'd0);
        chk("tis1_skip",  16'(dut.r_skip), 16'd0);
        tick(2);
        chk("tis2_skip",  16'(dut.r_skip), 16'd1);
        tick(2);
        chk("tis_skipped_acc", 16'(dut.r_acc), 16'd0);
        tick(2);
        chk("after_tis_acc", 16'(dut.r_acc), 16'd1);

        // TML call and RTN1 return-with-skip
        do_reset();
        put(8'h7D); put(8'h50); put(8'h34); put(8'h32);
        rom[12'h150] = 8'h6F;
        tick(2);
        chk("tml_stage2", 16'(dut.r_stage), 16'd2);
        tick(2);
        chk("tml_target", 16'(rom_addr), 16'h0150);
        chk("tml_push",   16'(dut.r_stack_s), 16'h00F0);
        tick(2);
        chk("rtn1_addr", 16'(rom_addr), 16'h00F0);
        chk("rtn1_skip", 16'(dut.r_skip), 16'd1);
        tick(2);
        chk("rtn1_skipped_acc", 16'(dut.r_acc), 16'd0);
        tick(2);
        chk("after_rtn_acc", 16'(dut.r_acc), 16'd2);

        // RAM exchange, ADD11 with carry, TC
        do_reset();
        put(8'h40); put(8'h29); put(8'h10); put(8'h28); put(8'h67);
        put(8'h09); put(8'h34); put(8'h52); put(8'h31);
        tick(6);
        chk("exc_ram", 16'(dut.r_ram[0]), 16'd9);
        tick(6);
        chk("add11_acc",   16'(dut.r_acc), 16'd2);
        chk("add11_carry", 16'(dut.r_carry), 16'd1);
        chk("add11_skip",  16'(dut.r_skip), 16'd1);
        tick(6);
        chk("tc_acc", 16'(dut.r_acc), 16'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
